// File: rtl/simt_pkg.sv
// Shared encodings for the SIMT scheduler: CU states, fetcher/LSU handshake
// states and the thread-count port width helper.
package simt_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_FETCH     = 4'd1;
  localparam logic [3:0] ST_DECODE    = 4'd2;
  localparam logic [3:0] ST_REQ       = 4'd3;
  localparam logic [3:0] ST_WAIT      = 4'd4;
  localparam logic [3:0] ST_EXECUTE   = 4'd5;
  localparam logic [3:0] ST_WRITEBACK = 4'd6;
  localparam logic [3:0] ST_DONE      = 4'd7;
  localparam logic [3:0] ST_ERROR     = 4'd8;

  localparam logic [1:0] XS_IDLE = 2'd0;
  localparam logic [1:0] XS_REQ  = 2'd1;
  localparam logic [1:0] XS_WAIT = 2'd2;
  localparam logic [1:0] XS_DONE = 2'd3;

  // Width able to express thread counts 0..lanes inclusive.
  function automatic int tc_width(input int lanes);
    return (lanes < 1) ? 1 : $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/simt_group_select.sv
// Picks the lowest PC among live lanes and the mask of every live lane
// sitting at that PC (min-PC reconvergence, no lane-index priority).
module simt_group_select
  import simt_pkg::*;
#(
  parameter int PC_ADDR_WIDTH = 8,
  parameter int CU_WIDTH      = 4
) (
  input  logic [PC_ADDR_WIDTH*CU_WIDTH-1:0] pcs_i,
  input  logic [CU_WIDTH-1:0]               live_i,
  output logic [PC_ADDR_WIDTH-1:0]          fetch_pc_o,
  output logic [CU_WIDTH-1:0]               exec_mask_o
);

  always_comb begin
    fetch_pc_o = '1;
    for (int i = 0; i < CU_WIDTH; i++) begin
      if (live_i[i] && (pcs_i[i*PC_ADDR_WIDTH +: PC_ADDR_WIDTH] < fetch_pc_o)) begin
        fetch_pc_o = pcs_i[i*PC_ADDR_WIDTH +: PC_ADDR_WIDTH];
      end
    end
    exec_mask_o = '0;
    for (int i = 0; i < CU_WIDTH; i++) begin
      exec_mask_o[i] = live_i[i] && (pcs_i[i*PC_ADDR_WIDTH +: PC_ADDR_WIDTH] == fetch_pc_o);
    end
  end

endmodule

// File: rtl/simt_scheduler.sv
// Compute-unit scheduler with per-thread PCs, min-PC divergence handling,
// per-thread completion and a WAIT-stage watchdog.
module simt_scheduler
  import simt_pkg::*;
#(
  parameter int PC_ADDR_WIDTH = 8,
  parameter int CU_WIDTH      = 4,
  parameter int WAIT_TIMEOUT  = 255
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 cu_enable,
  input  logic [tc_width(CU_WIDTH)-1:0]        thread_count,
  input  logic                                 is_alu,
  input  logic                                 is_branch,
  input  logic                                 is_const,
  input  logic                                 is_load,
  input  logic                                 is_store,
  input  logic                                 is_ret,
  input  logic [1:0]                           fetch_state,
  input  logic [2*CU_WIDTH-1:0]                lsu_state,
  input  logic [PC_ADDR_WIDTH*CU_WIDTH-1:0]    next_pc,
  output logic [PC_ADDR_WIDTH-1:0]             fetch_pc,
  output logic [CU_WIDTH-1:0]                  exec_mask,
  output logic [CU_WIDTH-1:0]                  thread_done,
  output logic                                 rf_ren,
  output logic                                 rf_wen,
  output logic                                 mem_ren,
  output logic                                 mem_wen,
  output logic [3:0]                           cu_state,
  output logic                                 cu_complete,
  output logic                                 cu_error
);

  localparam int PW   = PC_ADDR_WIDTH;
  localparam int WD_W = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);

  logic [3:0]             state_q, state_d;
  logic [PW*CU_WIDTH-1:0] pc_q, pc_d;
  logic [CU_WIDTH-1:0]    done_q, done_d;
  logic [PW-1:0]          fetch_pc_q;
  logic [CU_WIDTH-1:0]    exec_mask_q;
  logic [3:0]             en_q, en_d;
  logic [WD_W-1:0]        wd_q, wd_d;

  logic [CU_WIDTH-1:0]    count_mask;
  logic [CU_WIDTH-1:0]    lane_busy;
  logic                   pending;
  logic [PW-1:0]          sel_pc;
  logic [CU_WIDTH-1:0]    sel_mask;
  logic                   enter_fetch;

  always_comb begin
    count_mask = '0;
    lane_busy  = '0;
    for (int i = 0; i < CU_WIDTH; i++) begin
      count_mask[i] = int'(thread_count) > i;
      lane_busy[i]  = (lsu_state[2*i +: 2] == XS_REQ) || (lsu_state[2*i +: 2] == XS_WAIT);
    end
  end

  // Only lanes in the executing group can hold the CU in WAIT.
  assign pending = |(exec_mask_q & lane_busy);

  // Selection looks at next-state PCs/done so the group is ready on FETCH entry.
  simt_group_select #(
    .PC_ADDR_WIDTH (PC_ADDR_WIDTH),
    .CU_WIDTH      (CU_WIDTH)
  ) u_group_select (
    .pcs_i       (pc_d),
    .live_i      (~done_d),
    .fetch_pc_o  (sel_pc),
    .exec_mask_o (sel_mask)
  );

  assign enter_fetch = (state_d == ST_FETCH) && (state_q != ST_FETCH);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      done_q      <= '0;
      fetch_pc_q  <= '0;
      exec_mask_q <= '0;
      en_q        <= '0;
      wd_q        <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      en_q    <= en_d;
      wd_q    <= wd_d;
      if (enter_fetch) begin
        fetch_pc_q  <= sel_pc;
        exec_mask_q <= sel_mask;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    en_d    = en_q;
    wd_d    = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (cu_enable) begin
          pc_d    = '0;
          done_d  = ~count_mask;
          en_d    = '0;
          wd_d    = '0;
          state_d = (count_mask == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fetch_state == XS_DONE) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        en_d    = {is_load | is_store | is_alu | is_branch,
                   is_load | is_alu | is_const,
                   is_load,
                   is_store};
        state_d = ST_REQ;
      end
      ST_REQ: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!pending) begin
          state_d = ST_EXECUTE;
        end else begin
          wd_d = wd_q + 1'b1;
          if ((WAIT_TIMEOUT != 0) && (int'(wd_q) + 1 >= WAIT_TIMEOUT)) begin
            state_d = ST_ERROR;
            en_d    = '0;
          end
        end
      end
      ST_EXECUTE: state_d = ST_WRITEBACK;
      ST_WRITEBACK: begin
        for (int i = 0; i < CU_WIDTH; i++) begin
          if (exec_mask_q[i]) begin
            if (is_ret) done_d[i] = 1'b1;
            else        pc_d[i*PW +: PW] = next_pc[i*PW +: PW];
          end
        end
        en_d    = '0;
        state_d = (&done_d) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        if (!cu_enable) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        en_d = '0;
        if (!cu_enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cu_state    = state_q;
    cu_complete = (state_q == ST_DONE);
    cu_error    = (state_q == ST_ERROR);
    fetch_pc    = fetch_pc_q;
    exec_mask   = exec_mask_q;
    thread_done = done_q;
    {rf_ren, rf_wen, mem_ren, mem_wen} = en_q;
  end

endmodule

// File: doc/simt_scheduler.md
Name: simt_scheduler

Overview:
- Next-generation compute-unit scheduler: steps the CU through FETCH/DECODE/REQ/WAIT/EXECUTE/WRITEBACK and drives the RF and memory enables.
- Adds per-thread PCs, a runtime thread count and branch-divergence handling. At any time only the lowest-PC group of threads executes (min-PC reconvergence).
- Adds per-thread completion and a WAIT-stage watchdog.
- Sits between the decoder/fetcher/LSUs and the per-thread ALU/RF lanes.

Parameters:
- PC_ADDR_WIDTH, 8, PC width in bits.
- CU_WIDTH, 4, number of thread lanes.
- WAIT_TIMEOUT, 255, maximum cycles spent in WAIT before ERROR; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- cu_enable  in  1  start / level-hold run request
- thread_count  in  $clog2(CU_WIDTH+1)  live threads; sampled on IDLE->FETCH
- is_alu, is_branch, is_const, is_load, is_store, is_ret  in  1 each  decoder flags, valid from DECODE onward
- fetch_state  in  2  fetcher state: 0 IDLE, 1 REQ, 2 WAIT, 3 DONE
- lsu_state  in  2*CU_WIDTH  packed; lane i at [2i+1:2i]; encoding as fetch_state
- next_pc  in  PC_ADDR_WIDTH*CU_WIDTH  packed per-lane next PC from the lane PC units
- fetch_pc  out  PC_ADDR_WIDTH  PC of the group being executed
- exec_mask  out  CU_WIDTH  lanes executing the current instruction
- thread_done  out  CU_WIDTH  per-lane completion bits
- rf_ren, rf_wen, mem_ren, mem_wen  out  1 each  enables, qualified downstream by exec_mask
- cu_state  out  4  current state
- cu_complete  out  1  all live threads done
- cu_error  out  1  watchdog fired

Behaviour:
- Reset (reset_n low at a clk edge):
  - state IDLE
  - all lane PCs, fetch_pc, exec_mask, thread_done, all enables, cu_complete, cu_error, watchdog counter = 0
  - Reset mid-operation aborts immediately; no partial writeback.
- State encoding: IDLE 0, FETCH 1, DECODE 2, REQ 3, WAIT 4, EXECUTE 5, WRITEBACK 6, DONE 7, ERROR 8.
- Live lane: i < live_count and thread_done[i] = 0.
  - live_count = min(thread_count, CU_WIDTH), latched on start.
- IDLE:
  - On cu_enable: clear PCs, thread_done, enables, cu_complete, cu_error; latch live_count.
  - live_count = 0 -> DONE with cu_complete = 1; else -> FETCH.
  - Lanes >= live_count are marked done at start.
- FETCH:
  - On entry (registered in the transition cycle): fetch_pc = min PC over live lanes; exec_mask = live lanes whose PC equals fetch_pc. Ties include every matching lane.
  - Holds until fetch_state == 3, then -> DECODE.
- DECODE (1 cycle) -> REQ:
  - rf_ren = load | store | alu | branch
  - rf_wen = load | alu | const
  - mem_ren = load; mem_wen = store
- REQ (1 cycle) -> WAIT; watchdog counter cleared.
- WAIT:
  - Advances to EXECUTE in the first cycle where no lane in exec_mask has lsu_state of 1 or 2. Lanes outside exec_mask are ignored.
  - The pending check is combinational, re-evaluated every cycle; no sticky flag.
  - Counter increments each stalled cycle. If WAIT_TIMEOUT != 0 and counter reaches WAIT_TIMEOUT -> ERROR.
- EXECUTE (1 cycle) -> WRITEBACK.
- WRITEBACK (1 cycle), for each lane in exec_mask:
  - is_ret -> set thread_done[i], PC held
  - else -> PC[i] <= next_pc lane i
  - Lanes outside exec_mask hold their PC.
  - Enables cleared.
  - If no live lane remains after the update -> DONE with cu_complete = 1; else -> FETCH.
- DONE: holds cu_complete = 1; returns to IDLE when cu_enable = 0.
- ERROR: cu_error = 1, enables 0; returns to IDLE when cu_enable = 0.
- PCs wrap modulo 2^PC_ADDR_WIDTH; no overflow detection.
- Min-PC ties resolve equally (mask-based), so there is no lane-index priority.
- Decoder flags are sampled only in DECODE (enables) and WRITEBACK (is_ret).

Decomposition:
- Shared package simt_pkg:
  - CU state localparams (0-8)
  - fetcher/LSU state localparams (0-3)
  - helper for $clog2 thread-count width
- One sub-module: simt_group_select. Combinational min-PC reduction and equality mask over CU_WIDTH lanes (inputs: packed PCs, live mask; outputs: fetch_pc, exec_mask). Instantiated once and registered by the scheduler.

Test Plan:
- Uniform run: CU_WIDTH=4, thread_count=4, next_pc = PC+1 for all lanes, is_ret at PC 3 -> exec_mask = 4'b1111 throughout; four FETCH..WRITEBACK loops; thread_done = 4'b1111; cu_complete = 1.
- Divergence: at PC 2, branch sends lanes 0,1 to PC 5 and lanes 2,3 to PC 3 -> next FETCH fetch_pc = 3, exec_mask = 4'b1100. At PC 5 both groups fetch with exec_mask = 4'b1111 (reconverged).
- Partial count: thread_count=2 -> thread_done starts 4'b1100 and exec_mask never exceeds 4'b0011. thread_count=0 -> cu_complete next cycle, no FETCH.
- LSU masking: exec_mask = 4'b0011, lane 3 lsu_state = 2 forever, lanes 0-1 go 1 -> 3 after 5 cycles -> EXECUTE entered on that cycle; no stall from lane 3.
- Watchdog: WAIT_TIMEOUT=8, lane 0 in exec_mask held at lsu_state 2 -> cu_state = 8 and cu_error = 1 after 8 WAIT cycles. Dropping cu_enable -> IDLE.
- Reset mid-WAIT: assert reset_n = 0 for one edge -> all outputs 0, cu_state = 0; restart runs cleanly from PC 0.
